alu_mul_seq: RTL and testbench

Multi-cycle unsigned 32x32→64 multiplier sequencer that reuses the existing 32-bit ripple ALU as its only adder. Each cycle it drives the ALU with a partial-product add and consumes the ALU sum and carry-out to perform one shift-add step. The block owns the ALU operand/op ports while busy and sits between the instruction control logic (start/done handshake) and the shared `alu32` instance.

---
 rtl/alu_mul_seq.sv | 94 +++++++++
 tb/tb_alu_mul_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Sequential unsigned 32x32->64 shift-add multiplier that borrows the shared
// 32-bit ALU as its only adder, one partial-product add per RUN cycle.
module alu_mul_seq #(
    parameter logic [2:0] OP_ADD = 3'b010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_cout
);

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [W-1:0]     hi;
    logic [W-1:0]     lo;
    logic [W-1:0]     mcand_r;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   step_c;

    // 33-bit ALU sum shifted right by one into the {hi,lo} pair
    assign step_c = {alu_cout, alu_out, lo[W-1:1]};

    assign alu_a  = hi;
    assign alu_b  = lo[0] ? mcand_r : '0;
    assign alu_op = OP_ADD;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == S_RUN);
            done  <= (state_next == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            mcand_r <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        hi      <= '0;
                        lo      <= mplier;
                        mcand_r <= mcand;
                        cnt     <= '0;
                    end
                end
                S_RUN: begin
                    {hi, lo} <= step_c;
                    cnt      <= CNT_W'(cnt + CNT_W'(1));
                    if (cnt == CNT_LAST) product <= step_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: models the shared ALU and scores products against a
// queue of expected 64-bit results pushed when each start is driven.
module tb_alu_mul_seq;

    localparam logic [2:0] OP_ADD = 3'b010;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_cout;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb[$];

    alu_mul_seq #(.OP_ADD(OP_ADD)) dut (
        .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
        .busy(busy), .done(done), .product(product),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_cout(alu_cout)
    );

    // Stand-in for the shared alu32 adder
    always_comb begin
        {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        sb.push_back({32'd0, a} * {32'd0, b});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns edges after the accept edge at which done is seen, and busy samples
    task automatic wait_done(output int cyc, output int busy_n, output bit seen);
        cyc = 0; busy_n = 0; seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (done) begin seen = 1'b1; break; end
            if (busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pop_exp(output logic [63:0] e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = 64'hDEAD_DEAD_DEAD_DEAD;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
        end
        n_tests++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== OP_ADD) begin
            n_fail++;
            $display("FAIL reset_alu: a=%h b=%h op=%b, want 0 0 %b", alu_a, alu_b, alu_op, OP_ADD);
        end
    endtask

    task automatic test_basic;
        int cyc, bn; bit seen; logic [63:0] e;
        do_start(32'd3, 32'd5);
        wait_done(cyc, bn, seen);
        pop_exp(e);
        n_tests++;
        if (!seen || cyc != 32) begin
            n_fail++;
            $display("FAIL basic_latency: seen=%0d edges=%0d, want 1 32", seen, cyc);
        end
        n_tests++;
        if (bn != 32) begin
            n_fail++;
            $display("FAIL basic_busy: busy cycles=%0d, want 32", bn);
        end
        n_tests++;
        if (product !== e || e !== 64'h0000_0000_0000_000F) begin
            n_fail++;
            $display("FAIL basic_product: got %h, want %h", product, e);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_carry;
        int cyc, bn; bit seen; logic [63:0] e;
        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, bn, seen);
        pop_exp(e);
        n_tests++;
        if (!seen || product !== 64'hFFFF_FFFE_0000_0001 || product !== e) begin
            n_fail++;
            $display("FAIL carry_product: seen=%0d got %h, want %h", seen, product, 64'hFFFF_FFFE_0000_0001);
        end
    endtask

    task automatic test_boundary;
        int cyc, bn; bit seen; logic [63:0] e;
        @(negedge clk);
        do_start(32'h8000_0000, 32'd2);
        wait_done(cyc, bn, seen);
        pop_exp(e);
        n_tests++;
        if (!seen || product !== 64'h0000_0001_0000_0000 || product !== e) begin
            n_fail++;
            $display("FAIL msb_product: seen=%0d got %h, want %h", seen, product, 64'h0000_0001_0000_0000);
        end
        @(negedge clk);
        do_start(32'd0, 32'h1234_5678);
        n_tests++;
        if (product !== 64'h0000_0001_0000_0000) begin
            n_fail++;
            $display("FAIL product_held: got %h during new run, want %h", product, 64'h0000_0001_0000_0000);
        end
        wait_done(cyc, bn, seen);
        pop_exp(e);
        n_tests++;
        if (!seen || product !== 64'd0 || product !== e) begin
            n_fail++;
            $display("FAIL zero_product: seen=%0d got %h, want 0", seen, product);
        end
    endtask

    task automatic test_start_ignored;
        int ndone; int nbusy; logic [63:0] e;
        @(negedge clk);
        do_start(32'd7, 32'd9);
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 80; i++) begin
            if (i == 5) begin start = 1'b1; mcand = 32'd100; end
            else start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    pop_exp(e);
                    n_tests++;
                    if (product !== e || e !== 64'd63) begin
                        n_fail++;
                        $display("FAIL ignore_product: got %h, want %h", product, 64'd63);
                    end
                    start = 1'b1; mcand = 32'd100;
                    @(negedge clk);
                    start = 1'b0;
                    continue;
                end
            end
            if (ndone > 0 && busy) nbusy++;
            @(negedge clk);
        end
        start = 1'b0;
        n_tests++;
        if (ndone != 1 || nbusy != 0) begin
            n_fail++;
            $display("FAIL ignore_single_run: done pulses=%0d busy after=%0d, want 1 0", ndone, nbusy);
        end
    endtask

    task automatic test_reset_abort;
        int ndone;
        @(negedge clk);
        do_start(32'd6, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        n_tests++;
        if (busy !== 1'b0 || product !== 64'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b product=%h done=%b, want 0 0 0", busy, product, done);
        end
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        n_tests++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: activity cycles=%0d, want 0", ndone);
        end
        begin
            int cyc, bn; bit seen; logic [63:0] e;
            do_start(32'd6, 32'd7);
            wait_done(cyc, bn, seen);
            pop_exp(e);
            n_tests++;
            if (!seen || product !== 64'd42 || product !== e) begin
                n_fail++;
                $display("FAIL abort_rerun: seen=%0d got %h, want %h", seen, product, 64'd42);
            end
        end
    endtask

    task automatic test_reset_start_same;
        @(negedge clk);
        reset = 1'b1; start = 1'b1; mcand = 32'd5; mplier = 32'd5;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority: busy=%b, want 0", busy);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || product !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_priority_hold: busy=%b product=%h, want 0 0", busy, product);
        end
    endtask

    task automatic test_random;
        int cyc, bn; bit seen; logic [63:0] e;
        logic [31:0] a, b;
        int bad = 0;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            b = $urandom;
            if (n % 10 == 1) a = 32'hFFFF_FFFF;
            if (n % 10 == 2) b = 32'hFFFF_FFFF;
            if (n % 17 == 3) b = 32'h8000_0001;
            do_start(a, b);
            wait_done(cyc, bn, seen);
            pop_exp(e);
            n_tests++;
            if (!seen || product !== e) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL random[%0d]: %h*%h got %h, want %h (seen=%0d)", n, a, b, product, e, seen);
                bad++;
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
        test_reset;
        test_basic;
        test_carry;
        test_boundary;
        test_start_ignored;
        test_reset_abort;
        test_reset_start_same;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
